// File: rtl/mem_pkg.sv
// Shared definitions for the Memoria data-port initiator: state encoding,
// port direction codes and the alignment helper.
package mem_pkg;

  // Access FSM states; also exported on the debug port of mem_port_master.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Op2RW encoding seen by Memoria.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Word accesses only: any set bit in the two byte-offset bits is an error.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_master.sv
// Memoria data-port initiator. Accepts one load/store at a time from the
// MEM stage, drives Op2En/Op2RW/ReadWriteAddr, owns the shared Data bus
// direction and returns a one-cycle response pulse.
//
// Request handshake: a request transfers on the rising clk edge where
// req_valid && req_ready are both 1; all request fields are captured on that
// edge. req_ready is 1 only in S_IDLE, so at most one access is in flight and
// a request presented while busy is simply not taken (the requester holds it).
// resp_valid is a single-cycle pulse with no back-pressure.
module mem_port_master
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              Op2En,
  output logic              Op2RW,
  output logic [ADDR_W-1:0] ReadWriteAddr,
  inout  wire  [DATA_W-1:0] Data,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;

  // The bus is driven only in the single write cycle; leaving S_WR (or an
  // async reset) releases it in the same cycle Op2RW drops back to read.
  assign Data      = (state == S_WR) ? wdata_q : {DATA_W{1'bz}};
  assign dbg_state = state;

  // Access FSM with all strobes and response signals registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      wdata_q       <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      Op2En         <= 1'b0;
      Op2RW         <= OP_READ;
      ReadWriteAddr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (is_misaligned(req_addr[1:0])) begin
              // No memory access for a bad address; answer next cycle.
              state      <= S_ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we) begin
              state         <= S_WR;
              Op2En         <= 1'b1;
              Op2RW         <= OP_WRITE;
              ReadWriteAddr <= req_addr;
              wdata_q       <= req_wdata;
            end else begin
              state         <= S_RD;
              Op2En         <= 1'b1;
              Op2RW         <= OP_READ;
              ReadWriteAddr <= req_addr;
              cnt           <= CNT_W'(RD_LATENCY - 1);
            end
          end
        end

        S_RD: begin
          // Strobes stay up until Memoria's read data has had time to arrive.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_rdata <= Data;
            Op2En      <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end
        end

        S_WR: begin
          // Single write cycle, then return the port to read/idle.
          Op2En      <= 1'b0;
          Op2RW      <= OP_READ;
          state      <= S_RESP;
          resp_valid <= 1'b1;
        end

        S_RESP, S_ERR: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          Op2En      <= 1'b0;
          Op2RW      <= OP_READ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: a RD_LATENCY=1 instance with a scoreboarded
// request stream and bus checker, plus a RD_LATENCY=3 instance for the
// long-latency read timing. The Data nets are pulled high so a released bus
// reads as all ones.
module tb_mem_port_master;
  import mem_pkg::*;

  localparam int W     = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (latency 1) ----------------
  logic         req_valid = 1'b0;
  logic         req_we    = 1'b0;
  logic [W-1:0] req_addr  = '0;
  logic [W-1:0] req_wdata = '0;
  logic         req_ready, resp_valid, resp_err, op_en, op_rw;
  logic [W-1:0] resp_rdata, rw_addr;
  tri1  [W-1:0] data_a;
  state_t       dbg_a;

  mem_port_master #(.DATA_W(W), .ADDR_W(W), .RD_LATENCY(LAT_A)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Op2En(op_en), .Op2RW(op_rw), .ReadWriteAddr(rw_addr), .Data(data_a),
    .dbg_state(dbg_a)
  );

  // ---------------- instance B (latency 3) ----------------
  logic         b_req_valid = 1'b0;
  logic         b_req_we    = 1'b0;
  logic [W-1:0] b_req_addr  = '0;
  logic [W-1:0] b_req_wdata = '0;
  logic         b_req_ready, b_resp_valid, b_resp_err, b_en, b_rw;
  logic [W-1:0] b_resp_rdata, b_addr;
  tri1  [W-1:0] data_b;
  state_t       dbg_b;

  mem_port_master #(.DATA_W(W), .ADDR_W(W), .RD_LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .Op2En(b_en), .Op2RW(b_rw), .ReadWriteAddr(b_addr), .Data(data_b),
    .dbg_state(dbg_b)
  );

  // Initial memory contents: word 2 holds 0xDEADBEEF.
  function automatic logic [W-1:0] init_word(input int i);
    return (i == 2) ? 32'hDEAD_BEEF : (32'h1000_0000 + W'(i));
  endfunction

  // ---------------- Memoria models ----------------
  // Read data is only presented once the strobe has been held for
  // RD_LATENCY cycles; before that the bus floats.
  logic [W-1:0] mem_a [16];
  logic [W-1:0] mem_b [16];
  logic         init_a = 1'b0;
  logic         init_b = 1'b0;
  logic [3:0]   rdc_a, rdc_b;

  always @(posedge clk) begin
    if (!init_a) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= init_word(i);
      init_a <= 1'b1;
    end else if (op_en && op_rw) begin
      mem_a[rw_addr[5:2]] <= data_a;
    end
  end

  always @(posedge clk) begin
    if (!init_b) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= init_word(i);
      init_b <= 1'b1;
    end else if (b_en && b_rw) begin
      mem_b[b_addr[5:2]] <= data_b;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               rdc_a <= '0;
    else if (op_en && !op_rw) rdc_a <= rdc_a + 1'b1;
    else                      rdc_a <= '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rdc_b <= '0;
    else if (b_en && !b_rw) rdc_b <= rdc_b + 1'b1;
    else                    rdc_b <= '0;
  end

  assign data_a = (op_en && !op_rw && rdc_a >= 4'(LAT_A - 1)) ? mem_a[rw_addr[5:2]] : 'z;
  assign data_b = (b_en && !b_rw && rdc_b >= 4'(LAT_B - 1)) ? mem_b[b_addr[5:2]] : 'z;

  // ---------------- comparison helper ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {err, latency[7:0], rdata[31:0]}; accept cycle kept alongside.
  logic [W+8:0] exp_q[$];
  int           acc_q[$];
  logic [W+8:0] sb_e;
  int           sb_a;
  int           resp_cnt = 0;
  logic [W-1:0] model_mem [16];
  logic [W-1:0] last_rd = '0;

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_resp", resp_valid, 1'b0);
      end else begin
        sb_e = exp_q.pop_front();
        sb_a = acc_q.pop_front();
        check("sb_err",     resp_err, sb_e[W+8]);
        check("sb_rdata",   resp_rdata, sb_e[W-1:0]);
        check("sb_latency", cyc - sb_a, sb_e[W+7:W]);
      end
    end
  end

  // Bus checker: with the port disabled the bus is released and Op2RW is low.
  always @(negedge clk) begin
    if (rst_n && !op_en) begin
      check("bus_released_idle", data_a, 32'hFFFF_FFFF);
      check("rw_low_when_idle",  op_rw, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request and waits for acceptance; returns right after the
  // accepting edge with req_valid still high.
  task automatic do_req(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    logic         err;
    logic [W-1:0] exp_rd;
    logic [7:0]   lat;
    int           g;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    err = (addr[1:0] != 2'b00);
    if (err) begin
      exp_rd = last_rd;
      lat    = 8'd1;
    end else if (we) begin
      model_mem[addr[5:2]] = wdata;
      exp_rd = last_rd;
      lat    = 8'd2;
    end else begin
      exp_rd  = model_mem[addr[5:2]];
      last_rd = exp_rd;
      lat     = 8'(LAT_A + 1);
    end
    exp_q.push_back({err, lat, exp_rd});
    acc_q.push_back(cyc);
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready",  req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err",   resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_op_en",      op_en, 1'b0);
    check("rst_op_rw",      op_rw, 1'b0);
    check("rst_rw_addr",    rw_addr, 32'h0);
    check("rst_data_rel",   data_a, 32'hFFFF_FFFF);
    check("rst_state",      dbg_a, S_IDLE);
    rst_n = 1'b1;

    // Load word 2
    do_req(1'b0, 32'h8, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("ld_op_en",   op_en, 1'b1);
    check("ld_op_rw",   op_rw, 1'b0);
    check("ld_addr",    rw_addr, 32'h8);
    check("ld_state",   dbg_a, S_RD);
    check("ld_no_resp", resp_valid, 1'b0);
    @(negedge clk);
    check("ld_resp_valid", resp_valid, 1'b1);
    check("ld_rdata",      resp_rdata, 32'hDEAD_BEEF);
    check("ld_op_en_drop", op_en, 1'b0);
    wait_drain();

    // Store then load back
    do_req(1'b1, 32'h4, 32'h1234_5678);
    @(negedge clk);
    req_valid = 1'b0;
    check("st_data_drv", data_a, 32'h1234_5678);
    check("st_op_rw",    op_rw, 1'b1);
    check("st_op_en",    op_en, 1'b1);
    check("st_addr",     rw_addr, 32'h4);
    @(negedge clk);
    check("st_resp_valid", resp_valid, 1'b1);
    check("st_data_rel",   data_a, 32'hFFFF_FFFF);
    check("st_rdata_kept", resp_rdata, 32'hDEAD_BEEF);
    wait_drain();
    do_req(1'b0, 32'h4, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();
    check("st_ld_rdata", resp_rdata, 32'h1234_5678);

    // Misaligned load
    do_req(1'b0, 32'h6, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mis_resp_valid", resp_valid, 1'b1);
    check("mis_resp_err",   resp_err, 1'b1);
    check("mis_op_en",      op_en, 1'b0);
    check("mis_rdata_kept", resp_rdata, 32'h1234_5678);
    @(negedge clk);
    check("mis_pulse_end",  resp_valid, 1'b0);
    check("mis_err_end",    resp_err, 1'b0);
    wait_drain();

    // Back-to-back alternating store/load with req_valid held high,
    // including the top word address.
    base = resp_cnt;
    do_req(1'b1, 32'h10, 32'hA5A5_0001);
    do_req(1'b0, 32'h10, 32'h0);
    do_req(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D);
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();
    check("b2b_resp_count", resp_cnt - base, 4);
    check("b2b_last_rdata", resp_rdata, 32'h0BAD_F00D);

    // Reset in the middle of a read
    do_req(1'b0, 32'h8, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_rd_op_en", op_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_op_en",     op_en, 1'b0);
    check("arst_data_rel",  data_a, 32'hFFFF_FFFF);
    check("arst_req_ready", req_ready, 1'b1);
    check("arst_state",     dbg_a, S_IDLE);
    exp_q.delete();
    acc_q.delete();
    last_rd = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("arst_no_resp", resp_valid, 1'b0);
    end
    check("arst_rdata_cleared", resp_rdata, 32'h0);
    do_req(1'b0, 32'h4, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();

    // Long read latency on instance B
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_we    = 1'b0;
    b_req_addr  = 32'h8;
    check("lat3_ready", b_req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    for (int k = 1; k <= LAT_B; k++) begin
      check("lat3_op_en",   b_en, 1'b1);
      check("lat3_no_resp", b_resp_valid, 1'b0);
      @(negedge clk);
    end
    check("lat3_resp_valid", b_resp_valid, 1'b1);
    check("lat3_rdata",      b_resp_rdata, 32'hDEAD_BEEF);
    check("lat3_op_en_drop", b_en, 1'b0);
    @(negedge clk);
    check("lat3_pulse_end",  b_resp_valid, 1'b0);

    // Final report
    check("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
